adc_speed_ctrl: RTL
===================

Name: adc_speed_ctrl

Overview:
- Consumes the 16-bit AUX1 measurement register from the XADC DRP reader.
- Low-pass filters it, quantizes it to a speed level with hysteresis, and generates the one-cycle MOVE_TICK that steps the snake.
- Sits between the XADC wrapper and the game FSM; SPEED_LEVEL also drives the HUD/7-seg.
- Higher pot voltage gives a higher level, which gives faster ticks.

Parameters:
- SAMPLE_DIV, 100000: DCLK cycles between samples of MEASURED_AUX1.
- AVG_LOG2, 3: average 2^AVG_LOG2 samples.
- LEVEL_BITS, 3: speed level width (2^LEVEL_BITS levels).
- HYST, 16: hysteresis margin in ADC codes.
- BASE_PERIOD, 25000000: tick period at level 0, in DCLK cycles.
- STEP_PERIOD, 2500000: period reduction per level. Must hold BASE_PERIOD > (2^LEVEL_BITS-1)*STEP_PERIOD.
- CNT_W, 25: tick counter width. Must hold 2^CNT_W > BASE_PERIOD.

Ports:
- DCLK  in  1  system/DRP clock.
- RESET_N  in  1  asynchronous active-low reset.
- MEASURED_AUX1  in  16  XADC AUX1 result; code in [15:4], DCLK domain.
- ENABLE  in  1  game running; low = paused/idle.
- MOVE_TICK  out  1  one-cycle move strobe.
- SPEED_LEVEL  out  LEVEL_BITS  current accepted level.
- LEVEL_VALID  out  1  high once the first average is accepted.
- AVG_CODE  out  12  last averaged ADC code.

Behaviour:
- Clock and reset: one clock DCLK; reset RESET_N is asynchronous, active-low.
- Reset: all outputs 0, all counters/accumulators 0, FSM in IDLE. Assertion takes effect immediately without a clock edge. Deassertion is synchronized at top level.
- Sampling: code = MEASURED_AUX1[15:4], unsigned 12-bit. Sample counter runs 0..SAMPLE_DIV-1; its terminal count is the sample strobe.
- Averaging:
  - On each strobe: acc += code; n++. Accumulator width 12+AVG_LOG2; it cannot overflow.
  - On the strobe where n == 2^AVG_LOG2-1: AVG_CODE <= (acc+code)>>AVG_LOG2 (truncate), acc <= 0, n <= 0, and avg_done pulses the next cycle.
- Quantizer (evaluated on avg_done only): BIN = 4096>>LEVEL_BITS; raw = AVG_CODE[11:12-LEVEL_BITS].
  - First avg_done after reset: SPEED_LEVEL <= raw, LEVEL_VALID <= 1, unconditionally.
  - raw > cur: accept if AVG_CODE >= raw*BIN + HYST.
  - raw < cur: accept if AVG_CODE <= (raw+1)*BIN - 1 - HYST.
  - Otherwise hold. Multi-level jumps are allowed in one update.
- Tick FSM:
  - IDLE: tick counter = 0, MOVE_TICK = 0. Move to RUN when ENABLE && LEVEL_VALID; latch P = BASE_PERIOD - SPEED_LEVEL*STEP_PERIOD on that transition.
  - RUN: counter increments each cycle. When counter == P-1: MOVE_TICK = 1 for exactly one cycle, counter <= 0, and P re-latched from the current SPEED_LEVEL. First tick occurs exactly P cycles after entering RUN; thereafter one tick every P cycles.
  - Level changes mid-interval never shorten or stretch the interval in progress.
  - ENABLE low in RUN: go to IDLE the next cycle, counter cleared. No tick is issued on the cycle ENABLE is sampled low, even if the counter is at terminal count.
- Sampling and averaging run regardless of ENABLE.
- MOVE_TICK is registered (glitch-free).

Decomposition:
- Package snake_speed_pkg: CODE_W=12, LEVEL_BITS default, function period_of(level) returning BASE_PERIOD - level*STEP_PERIOD.
- Sub-module adc_boxcar_avg: sample divider, accumulator, and avg_done/AVG_CODE generation.
- Quantizer and tick FSM stay in the top level.

Test Plan (SAMPLE_DIV=4, AVG_LOG2=2, LEVEL_BITS=3, HYST=16, BASE_PERIOD=100, STEP_PERIOD=10):
- Release reset, AUX1=16'h8000 (code 2048) -> AVG_CODE=2048, SPEED_LEVEL=4, LEVEL_VALID=1 after 16 cycles; ENABLE=1 -> MOVE_TICK every 60 cycles, first tick 60 cycles after entering RUN.
- Hysteresis up from level 4: code 2568 -> level stays 4; code 2576 -> level 5, period 50. Hysteresis down from level 5: code 2551 -> stays 5; code 2543 -> level 4.
- Level 4->5 change 20 cycles after a tick -> next tick still 60 cycles after the previous one, following tick 50 cycles later.
- ENABLE dropped on the cycle counter==P-1 -> no MOVE_TICK; re-enable -> first tick exactly P cycles after entering RUN.
- Code 0 -> level 0, tick period 100; code 4095 -> level 7, tick period 30.
- RESET_N asserted mid-RUN between clock edges -> MOVE_TICK, SPEED_LEVEL, LEVEL_VALID, AVG_CODE read 0 immediately; after release, no tick until a full average completes and ENABLE is high.

Source files
------------

// File: rtl/snake_speed_pkg.sv
// -----------------------------------------------------------------------------
// snake_speed_pkg
// Shared constants, types and helpers for the pot-controlled snake speed path.
//   CODE_W              width of the XADC result code (MEASURED_AUX1[15:4])
//   LEVEL_BITS_DEFAULT  default speed-level width
//   tick_state_t        tick generator states
//   period_of()         tick period for a given speed level
// -----------------------------------------------------------------------------
package snake_speed_pkg;

  localparam int CODE_W             = 12;
  localparam int LEVEL_BITS_DEFAULT = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tick_state_t;

  // Higher level means a shorter period, i.e. a faster snake.
  function automatic int period_of(input int level,
                                   input int base_period,
                                   input int step_period);
    return base_period - level * step_period;
  endfunction

endpackage

// File: rtl/adc_boxcar_avg.sv
// -----------------------------------------------------------------------------
// adc_boxcar_avg
// Samples the ADC code once every SAMPLE_DIV clocks and averages blocks of
// 2^AVG_LOG2 samples (non-overlapping boxcar).
// Ports:
//   dclk      in   clock
//   rst_n     in   async active-low reset (already deassertion-synchronized)
//   code      in   CODE_W unsigned ADC code
//   avg_done  out  one-cycle pulse, the cycle after avg_code was updated
//   avg_code  out  CODE_W truncated average of the last block
// -----------------------------------------------------------------------------
module adc_boxcar_avg
  import snake_speed_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int AVG_LOG2   = 3
) (
  input  logic              dclk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  output logic              avg_done,
  output logic [CODE_W-1:0] avg_code
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [N_W-1:0]   n_cnt;
  logic             strobe;
  logic             last_sample;

  assign strobe      = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign last_sample = (n_cnt == N_W'((1 << AVG_LOG2) - 1));
  // Sum of 2^AVG_LOG2 codes always fits in ACC_W bits.
  assign acc_next    = acc + ACC_W'(code);

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      acc      <= '0;
      n_cnt    <= '0;
      avg_done <= 1'b0;
      avg_code <= '0;
    end else begin
      avg_done <= 1'b0;
      div_cnt  <= strobe ? '0 : div_cnt + 1'b1;
      if (strobe) begin
        if (last_sample) begin
          avg_code <= acc_next[ACC_W-1:AVG_LOG2];
          acc      <= '0;
          n_cnt    <= '0;
          avg_done <= 1'b1;
        end else begin
          acc   <= acc_next;
          n_cnt <= n_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_speed_ctrl.sv
// -----------------------------------------------------------------------------
// adc_speed_ctrl
// Turns the AUX1 pot reading into a speed level (with hysteresis) and a
// periodic one-cycle move strobe for the snake game FSM.
// Ports:
//   DCLK           in   system/DRP clock
//   RESET_N        in   async active-low reset (deassertion synchronized here)
//   MEASURED_AUX1  in   16-bit XADC AUX1 result, code in [15:4]
//   ENABLE         in   game running; low = paused/idle
//   MOVE_TICK      out  registered one-cycle move strobe
//   SPEED_LEVEL    out  current accepted speed level
//   LEVEL_VALID    out  high once the first average has been accepted
//   AVG_CODE       out  last averaged ADC code
//
// Tick FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | counter held at 0, no ticks; waits for ENABLE && LEVEL_VALID
//   ST_RUN  | counting; tick at period-1, period re-latched at each tick
// -----------------------------------------------------------------------------
module adc_speed_ctrl
  import snake_speed_pkg::*;
#(
  parameter int SAMPLE_DIV  = 100000,
  parameter int AVG_LOG2    = 3,
  parameter int LEVEL_BITS  = LEVEL_BITS_DEFAULT,
  parameter int HYST        = 16,
  parameter int BASE_PERIOD = 25000000,
  parameter int STEP_PERIOD = 2500000,
  parameter int CNT_W       = 25
) (
  input  logic                  DCLK,
  input  logic                  RESET_N,
  input  logic [15:0]           MEASURED_AUX1,
  input  logic                  ENABLE,
  output logic                  MOVE_TICK,
  output logic [LEVEL_BITS-1:0] SPEED_LEVEL,
  output logic                  LEVEL_VALID,
  output logic [CODE_W-1:0]     AVG_CODE
);

  localparam int BIN = 4096 >> LEVEL_BITS;

  // Reset: asserts asynchronously, releases two clocks after RESET_N rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge DCLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Sub-LSB nibble of the XADC result carries no information.
  logic unused_aux_lsb;
  assign unused_aux_lsb = ^MEASURED_AUX1[3:0];

  logic avg_done;

  adc_boxcar_avg #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .AVG_LOG2   (AVG_LOG2)
  ) u_avg (
    .dclk     (DCLK),
    .rst_n    (rst_n),
    .code     (MEASURED_AUX1[15:4]),
    .avg_done (avg_done),
    .avg_code (AVG_CODE)
  );

  // Quantizer: a move to a new bin must clear that bin's edge by HYST codes.
  logic [LEVEL_BITS-1:0] raw;
  logic [LEVEL_BITS-1:0] level_nxt;
  logic                  valid_nxt;
  int                    avg_i;
  int                    up_thr;
  int                    dn_thr;

  assign raw = AVG_CODE[CODE_W-1 -: LEVEL_BITS];

  always_comb begin
    avg_i     = int'(AVG_CODE);
    up_thr    = int'(raw) * BIN + HYST;
    dn_thr    = (int'(raw) + 1) * BIN - 1 - HYST;
    level_nxt = SPEED_LEVEL;
    valid_nxt = LEVEL_VALID;
    if (avg_done) begin
      if (!LEVEL_VALID) begin
        level_nxt = raw;
        valid_nxt = 1'b1;
      end else if ((raw > SPEED_LEVEL) && (avg_i >= up_thr)) begin
        level_nxt = raw;
      end else if ((raw < SPEED_LEVEL) && (avg_i <= dn_thr)) begin
        level_nxt = raw;
      end
    end
  end

  always_ff @(posedge DCLK or negedge rst_n) begin
    if (!rst_n) begin
      SPEED_LEVEL <= '0;
      LEVEL_VALID <= 1'b0;
    end else begin
      SPEED_LEVEL <= level_nxt;
      LEVEL_VALID <= valid_nxt;
    end
  end

  // Tick FSM
  tick_state_t      state;
  tick_state_t      state_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] period_cur;
  logic             tick_nxt;

  assign period_cur = CNT_W'(period_of(int'(SPEED_LEVEL), BASE_PERIOD, STEP_PERIOD));

  always_ff @(posedge DCLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      period_q  <= '0;
      MOVE_TICK <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= cnt_nxt;
      period_q  <= period_nxt;
      MOVE_TICK <= tick_nxt;
    end
  end

  // The period only changes at a tick (or on entry to RUN), so a level
  // change never alters the interval already in progress.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = tick_cnt;
    period_nxt = period_q;
    tick_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (ENABLE && LEVEL_VALID) begin
          state_nxt  = ST_RUN;
          period_nxt = period_cur;
        end
      end
      ST_RUN: begin
        if (!ENABLE) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (tick_cnt == period_q - 1'b1) begin
          tick_nxt   = 1'b1;
          cnt_nxt    = '0;
          period_nxt = period_cur;
        end else begin
          cnt_nxt = tick_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
